run_length_detector: RTL and testbench
======================================

# run_length_detector

- Parametrised serial run-length detector for the keying front end.
- Samples a 1-bit input on a sample strobe and flags when RUN_LEN consecutive identical bits have been seen. It reports which polarity matched and the current run length.
- Successor to the fixed four-in-a-row one-hot detector. Adds parametrised run length, a selectable saturating/non-overlapping mode, a sample enable, a synchronous clear and a detection pulse.
- Feeds the Morse symbol classifier: runs of 1 mark dashes, runs of 0 mark letter gaps.

## Interface

Parameters:
- RUN_LEN, 4, number of consecutive identical samples for a match; legal range 2..255.
- DCNT_W, 8, width of the detection counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; reset is sampled on the rising edge of clk.
- clr  in  1  synchronous clear to IDLE; reset has priority over clr.
- en  in  1  sample strobe; w is consumed only in cycles with en=1.
- w  in  1  serial input bit.
- mode  in  1  0 = saturating, 1 = non-overlapping; sampled every en cycle.
- z  out  1  level: current run has reached RUN_LEN under the active mode.
- z_val  out  1  polarity of the current run; valid when z=1.
- z_pulse  out  1  one-cycle pulse per detection event.
- run_cnt  out  CW  current run length; CW = $clog2(RUN_LEN+1).
- busy  out  1  1 when not in IDLE.
- det_count  out  DCNT_W  detection event count; see Configuration.

## Operation

- States, binary-encoded: IDLE, ZERO, ONE. ZERO and ONE mean the current run is 0s or 1s.
- Registers: state, cnt (CW bits), z_pulse_r, det_count_r.
- Priority per clock edge: reset=0, then clr=1, then en=1, then hold.
  - reset=0 or clr=1 → state=IDLE, cnt=0, z_pulse=0.
  - clr does not clear det_count; only reset does.
- en=0 → all state held; z_pulse=0.
- en=1 from IDLE → state=ZERO if w=0, else ONE; cnt=1.
- en=1 with w differing from the current run polarity → switch to the other run state; cnt=1.
- en=1 with w matching the current run polarity:
  - mode=0: cnt = min(cnt+1, RUN_LEN); cnt stays at RUN_LEN while the run continues.
  - mode=1: if cnt==RUN_LEN then cnt=1, else cnt=cnt+1. This partitions a long run into disjoint RUN_LEN groups.
- Outputs:
  - z = (state≠IDLE) & (cnt==RUN_LEN).
  - z_val = (state==ONE).
  - run_cnt = cnt.
  - busy = (state≠IDLE).
- Detection event: an en=1 sample that moves cnt from RUN_LEN-1 to RUN_LEN. A sample that holds cnt at RUN_LEN in mode=0 is not an event.
- mode changed mid-run takes effect on the next en sample; cnt is not reset.
- Arithmetic: cnt never exceeds RUN_LEN; no wrap occurs in mode=0.

## Timing

- Reset values:
  - state=IDLE, cnt=0.
  - z=0, z_val=0, z_pulse=0, run_cnt=0, busy=0, det_count=0.
- All outputs are registered or decoded directly from registers; no combinational path from inputs to outputs.
- z latency: z rises in the cycle after the edge that captures the RUN_LEN-th matching sample.
- z_pulse: high for exactly that one cycle per event.
- z fall:
  - mode=1: z falls after the next en sample.
  - mode=0: z falls only on a polarity change, clr or reset.
- Back-to-back en (every cycle) is supported; at most one sample is consumed per clock.
- clr and en in the same cycle: clr wins and the sample is discarded.

## Configuration

- RUN_DET_COUNT_EN defined:
  - det_count_r increments by 1 on each z_pulse cycle and saturates at all-ones.
  - Cleared only by reset.
- RUN_DET_COUNT_EN undefined:
  - No counter logic is built; det_count is tied to 0.
  - The port stays present so the interface is stable.

## Test plan

All scenarios use RUN_LEN=4 unless noted.

- Reset/hold: reset=0 for 2 cycles, then en=0 for 10 cycles with w toggling → all outputs 0, busy=0.
- Saturating: mode=0, en=1, w=1 for 6 samples:
  - run_cnt = 1,2,3,4,4,4.
  - z=1 and z_val=1 from the cycle after sample 4.
  - Exactly one z_pulse.
  - One sample w=0 → z=0, run_cnt=1, z_val=0.
- Non-overlap: mode=1, w=0 for 8 consecutive en samples:
  - z_pulse after samples 4 and 8.
  - run_cnt sequence 1,2,3,4,1,2,3,4.
  - det_count=2 with RUN_DET_COUNT_EN.
- Gapped strobe: w=1 with en=1 on alternating cycles → detection occurs only after the 4th strobed sample; idle cycles do not advance cnt.
- clr vs en: run_cnt=3 (w=1), then clr=1 and en=1 with w=1 in the same cycle:
  - state=IDLE, z=0, no pulse.
  - det_count unchanged.
- Reset mid-run: reset=0 while z=1 → next cycle all outputs 0, det_count=0.
- Parameter sweep: RUN_LEN=2 and RUN_LEN=255 → pulse after exactly 2 and 255 samples respectively; cnt never exceeds RUN_LEN.

Source files
------------

// File: rtl/run_length_detector.sv
// Serial run-length detector: flags RUN_LEN consecutive identical strobed samples.
// Optional detection counter built when RUN_DET_COUNT_EN is defined.
module run_length_detector #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned DCNT_W  = 8,
  localparam int unsigned CW     = $clog2(RUN_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              w,
  input  logic              mode,
  output logic              z,
  output logic              z_val,
  output logic              z_pulse,
  output logic [CW-1:0]     run_cnt,
  output logic              busy,
  output logic [DCNT_W-1:0] det_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ZERO = 2'd1;
  localparam logic [1:0] ONE  = 2'd2;

  localparam logic [CW-1:0] RUN_MAX  = CW'(RUN_LEN);
  localparam logic [CW-1:0] RUN_PRE  = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          z_pulse_r, pulse_n;
  logic          run_pol;

  assign run_pol = (state == ONE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pulse_n = 1'b0;
    if (en) begin
      if (state == IDLE || w != run_pol) begin
        state_n = w ? ONE : ZERO;
        cnt_n   = CNT_ONE;
      end else if (cnt == RUN_MAX) begin
        // Saturate in mode 0; start a fresh disjoint group in mode 1.
        cnt_n = mode ? CNT_ONE : RUN_MAX;
      end else begin
        cnt_n   = cnt + CNT_ONE;
        pulse_n = (cnt == RUN_PRE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      z_pulse_r <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      z_pulse_r <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      z_pulse_r <= pulse_n;
    end
  end

`ifdef RUN_DET_COUNT_EN
  logic [DCNT_W-1:0] det_count_r;

  // Counts alongside the pulse register so det_count moves with z_pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      det_count_r <= '0;
    end else if (!clr && pulse_n && det_count_r != '1) begin
      det_count_r <= det_count_r + DCNT_W'(1);
    end
  end

  assign det_count = det_count_r;
`else
  assign det_count = '0;
`endif

  assign z       = (state != IDLE) && (cnt == RUN_MAX);
  assign z_val   = run_pol;
  assign z_pulse = z_pulse_r;
  assign run_cnt = cnt;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: three instances (RUN_LEN 4, 2, 255) share one
// stimulus stream and are checked every cycle against a run/group model.
module tb_run_length_detector;

  logic clk = 1'b0;
  logic reset, clr, en, w, mode;

  logic       z4, zv4, zp4, b4;
  logic [2:0] rc4;
  logic [7:0] dc4;
  logic       z2, zv2, zp2, b2;
  logic [1:0] rc2;
  logic [7:0] dc2;
  logic       zf, zvf, zpf, bf;
  logic [7:0] rcf;
  logic [7:0] dcf;

  int checks = 0;
  int errors = 0;

  int R[3] = '{4, 2, 255};
  bit act[3];
  bit pol[3];
  int grp[3];
  bit pulse[3];
  int dc[3];

  always #5 clk = ~clk;

  run_length_detector #(.RUN_LEN(4), .DCNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .w(w), .mode(mode),
    .z(z4), .z_val(zv4), .z_pulse(zp4), .run_cnt(rc4), .busy(b4), .det_count(dc4)
  );

  run_length_detector #(.RUN_LEN(2), .DCNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .w(w), .mode(mode),
    .z(z2), .z_val(zv2), .z_pulse(zp2), .run_cnt(rc2), .busy(b2), .det_count(dc2)
  );

  run_length_detector #(.RUN_LEN(255), .DCNT_W(8)) dut255 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .w(w), .mode(mode),
    .z(zf), .z_val(zvf), .z_pulse(zpf), .run_cnt(rcf), .busy(bf), .det_count(dcf)
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: a run is a polarity plus its position within the current group.
  function automatic void model_step(bit r, bit c, bit e, bit wi, bit m);
    for (int k = 0; k < 3; k++) begin
      int prev;
      pulse[k] = 1'b0;
      if (!r) begin
        act[k] = 1'b0; grp[k] = 0; dc[k] = 0;
      end else if (c) begin
        act[k] = 1'b0; grp[k] = 0;
      end else if (e) begin
        if (!act[k] || pol[k] != wi) begin
          act[k] = 1'b1; pol[k] = wi; grp[k] = 1;
        end else begin
          prev = grp[k];
          if (m) grp[k] = (grp[k] % R[k]) + 1;
          else   grp[k] = (grp[k] + 1 > R[k]) ? R[k] : grp[k] + 1;
          pulse[k] = (prev == R[k] - 1) && (grp[k] == R[k]);
        end
`ifdef RUN_DET_COUNT_EN
        if (pulse[k] && dc[k] < 255) dc[k]++;
`endif
      end
    end
  endfunction

  task automatic check_dut(input int k, input string n, input bit zo, input bit zvo,
                           input bit zpo, input int rco, input bit bo, input int dco);
    chk({n, ".z"},       int'(zo),  int'(act[k] && grp[k] == R[k]));
    chk({n, ".z_val"},   int'(zvo), int'(act[k] && pol[k]));
    chk({n, ".z_pulse"}, int'(zpo), int'(pulse[k]));
    chk({n, ".run_cnt"}, rco,       grp[k]);
    chk({n, ".busy"},    int'(bo),  int'(act[k]));
    chk({n, ".det_cnt"}, dco,       dc[k]);
    chk({n, ".cnt_le"},  int'(rco <= R[k]), 1);
  endtask

  task automatic step(input bit r, input bit c, input bit e, input bit wi, input bit m);
    reset = r; clr = c; en = e; w = wi; mode = m;
    @(posedge clk);
    model_step(r, c, e, wi, m);
    #1;
    check_dut(0, "rl4",   z4, zv4, zp4, int'(rc4), b4, int'(dc4));
    check_dut(1, "rl2",   z2, zv2, zp2, int'(rc2), b2, int'(dc2));
    check_dut(2, "rl255", zf, zvf, zpf, int'(rcf), bf, int'(dcf));
  endtask

  initial begin
    int saved_dc;
    bit wr, mr, cr, rr, er;
    reset = 1'b0; clr = 1'b0; en = 1'b0; w = 1'b0; mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      act[k] = 0; pol[k] = 0; grp[k] = 0; pulse[k] = 0; dc[k] = 0;
    end
    #1;

    // Reset, then idle strobe with toggling input.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, i[0], 0);
    chk("idle.busy", int'(b4), 0);

    // Saturating run of ones, then a single zero.
    for (int i = 0; i < 6; i++) step(1, 0, 1, 1, 0);
    chk("sat.run_cnt", int'(rc4), 4);
    chk("sat.z", int'(z4), 1);
    step(1, 0, 1, 0, 0);
    chk("sat.break_cnt", int'(rc4), 1);
    chk("sat.break_zval", int'(zv4), 0);

    // Non-overlapping zeros: pulses after samples 4 and 8.
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 1);
    chk("novl.run_cnt", int'(rc4), 4);

    // Gapped strobe.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, i[0] == 1'b0, 1, 0);

    // clr collides with en: sample dropped, det_count untouched.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0);
    saved_dc = int'(dc4);
    step(1, 1, 1, 1, 0);
    chk("clr.busy", int'(b4), 0);
    chk("clr.det_keep", int'(dc4), saved_dc);

    // Reset mid-run while z is high.
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0);
    chk("rst.z_before", int'(z4), 1);
    step(0, 0, 1, 1, 0);
    chk("rst.z_after", int'(z4), 0);

    // Long runs exercise RUN_LEN=255 in both modes.
    for (int i = 0; i < 300; i++) step(1, 0, 1, 1, 0);
    chk("long.rl255_cnt", int'(rcf), 255);
    for (int i = 0; i < 520; i++) step(1, 0, 1, 0, 1);

    // Randomized traffic with occasional clr, reset and mode flips.
    wr = 1'b0; mr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 20) wr = ~wr;
      if ($urandom_range(0, 29) == 0) mr = ~mr;
      cr = ($urandom_range(0, 59) == 0);
      rr = ($urandom_range(0, 299) != 0);
      er = ($urandom_range(0, 2) != 0);
      step(rr, cr, er, wr, mr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
